// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: frame sequencer for the 3x3 sliding-window line buffer.
// Streams one IMG_W x IMG_H frame into the line buffer, clears the buffer at
// frame start and tags only fully populated windows for the downstream MAC.
module conv_window_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              m_ready,
    output logic              lb_rst,
    output logic              lb_in_valid,
    output logic [DATA_W-1:0] lb_pixel,
    output logic              win_valid,
    output logic [CNT_W-1:0]  win_row,
    output logic [CNT_W-1:0]  win_col,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
    // A 3x3 window is complete once two full rows/columns precede the pixel.
    localparam logic [CNT_W-1:0] WIN_EDGE = CNT_W'(2);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic             lb_rst_q, lb_rst_d;
    logic             win_valid_q, win_valid_d;
    logic [CNT_W-1:0] win_row_q, win_row_d;
    logic [CNT_W-1:0] win_col_q, win_col_d;
    logic             xfer;

    // Next-state, counter, window-tag and pixel pass-through decode.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        lb_rst_d    = 1'b0;
        win_valid_d = 1'b0;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        s_ready     = 1'b0;
        lb_in_valid = 1'b0;
        lb_pixel    = '0;
        xfer        = 1'b0;

        if (abort) begin
            // Abandon the frame; the source is not handshaked in this cycle.
            state_d   = S_IDLE;
            row_d     = '0;
            col_d     = '0;
            lb_rst_d  = 1'b1;
            win_row_d = '0;
            win_col_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_CLEAR;
                        lb_rst_d = 1'b1;
                    end
                end
                S_CLEAR: begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    s_ready = m_ready;
                    xfer    = s_valid & m_ready;
                    if (xfer) begin
                        lb_in_valid = 1'b1;
                        lb_pixel    = s_data;
                        if ((row_q >= WIN_EDGE) && (col_q >= WIN_EDGE)) begin
                            win_valid_d = 1'b1;
                            win_row_d   = row_q - WIN_EDGE;
                            win_col_d   = col_q - WIN_EDGE;
                        end
                        if (col_q == COL_LAST) begin
                            if (row_q == ROW_LAST) begin
                                // Counters park on the last pixel until the next CLEAR.
                                state_d = S_DRAIN;
                            end else begin
                                col_d = '0;
                                row_d = row_q + CNT_W'(1);
                            end
                        end else begin
                            col_d = col_q + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, counters and registered window tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            lb_rst_q    <= 1'b0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            lb_rst_q    <= lb_rst_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    assign lb_rst     = lb_rst_q;
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: randomized frame stimulus checked against a window-list
// model built from the output-map geometry.
module tb_conv_window_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IMG_W  = 5;
    localparam int unsigned IMG_H  = 5;
    localparam int unsigned CNT_W  = 16;
    localparam int          NPIX   = IMG_W * IMG_H;
    localparam int          NWIN   = (IMG_W - 2) * (IMG_H - 2);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              m_ready = 1'b0;
    logic              lb_rst;
    logic              lb_in_valid;
    logic [DATA_W-1:0] lb_pixel;
    logic              win_valid;
    logic [CNT_W-1:0]  win_row;
    logic [CNT_W-1:0]  win_col;
    logic              busy;
    logic              frame_done;

    int total = 0;
    int bad   = 0;

    conv_window_ctrl #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_ready(m_ready), .lb_rst(lb_rst), .lb_in_valid(lb_in_valid),
        .lb_pixel(lb_pixel), .win_valid(win_valid), .win_row(win_row),
        .win_col(win_col), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after the falling edge, then settle before sampling.
    task automatic drive(input logic st, input logic ab, input logic rs,
                         input logic sv, input logic mr, input logic [DATA_W-1:0] sd);
        @(negedge clk);
        start = st; abort = ab; rst = rs; s_valid = sv; m_ready = mr; s_data = sd;
        #1;
    endtask

    // One frame: vprob = s_valid probability (%), m_ready dropped for hold_len
    // cycles when pixel hold_at is next, start re-pulsed while pixel start_at
    // is next, and kill_kind 1=abort / 2=rst applied when pixel kill_at is next.
    task automatic frame(input int vprob, input int hold_at, input int hold_len,
                         input int start_at, input int kill_at, input int kill_kind);
        int   wr_q[$];
        int   wc_q[$];
        int   k = 0;
        int   cyc = 0;
        int   seen = 0;
        int   hold_left = 0;
        bit   held = 1'b0;
        logic exp_wv = 1'b0;
        logic sv, mr, st;

        for (int r = 0; r < int'(IMG_H) - 2; r++)
            for (int c = 0; c < int'(IMG_W) - 2; c++) begin
                wr_q.push_back(r);
                wc_q.push_back(c);
            end

        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_ready", 32'(s_ready), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
        chk("clear_lbrst", 32'(lb_rst), 1);
        chk("clear_busy", 32'(busy), 1);
        chk("clear_ready", 32'(s_ready), 0);
        chk("clear_lbin", 32'(lb_in_valid), 0);

        while (k < NPIX && cyc < 400) begin
            cyc++;
            if (kill_kind != 0 && k == kill_at) begin
                drive(1'b0, kill_kind == 1, kill_kind == 2, 1'b0, 1'b1, '0);
                if (kill_kind == 1) begin
                    chk("kill_wv", 32'(win_valid), 32'(exp_wv));
                    if (exp_wv && wr_q.size() > 0) begin
                        chk("kill_row", 32'(win_row), 32'(wr_q.pop_front()));
                        chk("kill_col", 32'(win_col), 32'(wc_q.pop_front()));
                    end
                end
                drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
                chk("kill_busy", 32'(busy), 0);
                chk("kill_ready", 32'(s_ready), 0);
                chk("kill_lbin", 32'(lb_in_valid), 0);
                chk("kill_wv0", 32'(win_valid), 0);
                chk("kill_done", 32'(frame_done), 0);
                chk("kill_lbrst", 32'(lb_rst), (kill_kind == 1) ? 32'd1 : 32'd0);
                if (kill_kind == 2) begin
                    chk("rst_row", 32'(win_row), 0);
                    chk("rst_col", 32'(win_col), 0);
                end
                drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
                chk("kill_lbrst_end", 32'(lb_rst), 0);
                chk("kill_idle", 32'(busy), 0);
                return;
            end
            if (k == hold_at && !held) begin
                hold_left = hold_len;
                held = 1'b1;
            end
            mr = (hold_left == 0);
            if (hold_left > 0) hold_left--;
            sv = ($urandom_range(99) < vprob);
            st = (k == start_at);
            drive(st, 1'b0, 1'b0, sv, mr, DATA_W'(k));
            chk("run_ready", 32'(s_ready), 32'(mr));
            chk("run_lbin", 32'(lb_in_valid), 32'(sv & mr));
            chk("run_lbrst", 32'(lb_rst), 0);
            chk("run_busy", 32'(busy), 1);
            chk("run_done", 32'(frame_done), 0);
            chk("run_wv", 32'(win_valid), 32'(exp_wv));
            if (exp_wv && win_valid === 1'b1 && wr_q.size() > 0) begin
                chk("win_row", 32'(win_row), 32'(wr_q.pop_front()));
                chk("win_col", 32'(win_col), 32'(wc_q.pop_front()));
                seen++;
            end
            if (sv && mr) begin
                chk("lb_pixel", 32'(lb_pixel), 32'(DATA_W'(k)));
                exp_wv = ((k / int'(IMG_W)) >= 2) && ((k % int'(IMG_W)) >= 2);
                k++;
            end else begin
                exp_wv = 1'b0;
            end
        end
        if (cyc >= 400) chk("timeout", 0, 1);

        // Drain: last window presented, no more pixels taken.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        chk("drain_busy", 32'(busy), 1);
        chk("drain_ready", 32'(s_ready), 0);
        chk("drain_lbin", 32'(lb_in_valid), 0);
        chk("drain_done", 32'(frame_done), 0);
        chk("drain_wv", 32'(win_valid), 1);
        if (win_valid === 1'b1 && wr_q.size() > 0) begin
            chk("last_row", 32'(win_row), 32'(wr_q.pop_front()));
            chk("last_col", 32'(win_col), 32'(wc_q.pop_front()));
            seen++;
        end
        // Done: start offered here must be ignored.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        chk("done_pulse", 32'(frame_done), 1);
        chk("done_busy", 32'(busy), 1);
        chk("done_wv", 32'(win_valid), 0);
        chk("done_ready", 32'(s_ready), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("post_done", 32'(frame_done), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_lbrst", 32'(lb_rst), 0);
        chk("win_count", 32'(seen), 32'(NWIN));
        chk("win_left", 32'(wr_q.size()), 0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(s_ready), 0);
        chk("rst_lbrst", 32'(lb_rst), 0);
        chk("rst_wv", 32'(win_valid), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_lbin", 32'(lb_in_valid), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Back-to-back frame, m_ready always high.
        frame(100, -1, 0, -1, -1, 0);
        // Random s_valid at 50%.
        frame(50, -1, 0, -1, -1, 0);
        // m_ready held low for 4 cycles mid-row 3.
        frame(100, 16, 4, -1, -1, 0);
        // Abort after pixel 10, then a fresh full frame.
        frame(100, -1, 0, -1, 11, 1);
        frame(70, -1, 0, -1, -1, 0);
        // start re-pulsed during RUN (and in DONE inside frame()).
        frame(80, 8, 2, 7, -1, 0);

        // start and abort together in IDLE: abort wins.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("sa_busy", 32'(busy), 0);
        chk("sa_lbrst", 32'(lb_rst), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("sa_idle", 32'(busy), 0);
        chk("sa_lbrst_end", 32'(lb_rst), 0);

        // rst mid-frame, then a clean frame.
        frame(100, -1, 0, -1, 13, 2);
        frame(60, 20, 3, -1, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
